// File: rtl/apb_priority_sequencer.sv
// ---------------------------------------------------------------------------
// apb_priority_sequencer
//   Programs the interrupt controller's per-peripheral priority registers
//   over APB. On start, the flat priority table is captured and written to
//   addresses 0..NO_OF_PERIPHERALS-1, one APB write per entry.
//   o_cfg_valid rises once the whole table has been written. A slave that
//   holds pready low too long aborts the run with a sticky error, and the
//   failing address is reported.
//
// Ports
//   i_pclk, i_presetn      clock, synchronous active-low reset
//   i_start                program request (only honoured when idle)
//   i_prio_table           entry i at [i*WIDTH +: WIDTH]
//   o_busy                 run in progress
//   o_cfg_valid            table fully programmed (level)
//   o_err, o_err_addr      last run timed out, and at which address
//   o_psel .. o_pwdata     APB master outputs (write-only)
//   i_pready               APB slave ready
// ---------------------------------------------------------------------------
module apb_priority_sequencer #(
   parameter int NO_OF_PERIPHERALS = 16,
   parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
   parameter int TIMEOUT_CYCLES    = 16
) (
   input  logic                               i_pclk,
   input  logic                               i_presetn,
   input  logic                               i_start,
   input  logic [NO_OF_PERIPHERALS*WIDTH-1:0] i_prio_table,
   output logic                               o_busy,
   output logic                               o_cfg_valid,
   output logic                               o_err,
   output logic [WIDTH-1:0]                   o_err_addr,
   output logic                               o_psel,
   output logic                               o_penable,
   output logic                               o_pwrite,
   output logic [WIDTH-1:0]                   o_paddr,
   output logic [WIDTH-1:0]                   o_pwdata,
   input  logic                               i_pready
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   // Counter is wide enough to hold TIMEOUT_CYCLES; 1 bit when disabled.
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NO_OF_PERIPHERALS - 1);
   localparam logic [TW-1:0]    TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [1:0]                         r_state;
   logic [NO_OF_PERIPHERALS*WIDTH-1:0] r_table;
   logic [WIDTH-1:0]                   r_idx;
   logic [TW-1:0]                      r_tcnt;
   logic                               r_busy, r_cfg_valid, r_err;
   logic [WIDTH-1:0]                   r_err_addr;
   logic                               r_psel, r_penable, r_pwrite;
   logic [WIDTH-1:0]                   r_paddr, r_pwdata;

   logic [WIDTH-1:0] w_nxt_idx;
   logic             w_timeout;

   assign w_nxt_idx = r_idx + WIDTH'(1);
   // This edge is the TIMEOUT_CYCLES-th ACCESS edge without pready.
   assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_tcnt == TO_LAST);

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_tcnt      <= '0;
         r_busy      <= 1'b0;
         r_cfg_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_addr  <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_table     <= i_prio_table;
                  r_idx       <= '0;
                  r_tcnt      <= '0;
                  r_cfg_valid <= 1'b0;
                  r_err       <= 1'b0;
                  r_busy      <= 1'b1;
                  r_psel      <= 1'b1;
                  r_penable   <= 1'b0;
                  r_pwrite    <= 1'b1;
                  r_paddr     <= '0;
                  r_pwdata    <= i_prio_table[WIDTH-1:0];
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready wins over a timeout on the same edge.
               if (i_pready || w_timeout) begin
                  if (i_pready && (r_idx != LAST_IDX)) begin
                     r_idx     <= w_nxt_idx;
                     r_tcnt    <= '0;
                     r_penable <= 1'b0;
                     r_paddr   <= w_nxt_idx;
                     r_pwdata  <= r_table[w_nxt_idx*WIDTH +: WIDTH];
                     r_state   <= ST_SETUP;
                  end else begin
                     // Run ends: either last write accepted or slave stalled.
                     r_busy    <= 1'b0;
                     r_psel    <= 1'b0;
                     r_penable <= 1'b0;
                     r_pwrite  <= 1'b0;
                     r_paddr   <= '0;
                     r_pwdata  <= '0;
                     r_state   <= ST_IDLE;
                     if (i_pready) begin
                        r_cfg_valid <= 1'b1;
                     end else begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_idx;
                     end
                  end
               end else if (TIMEOUT_CYCLES > 0) begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_cfg_valid = r_cfg_valid;
   assign o_err       = r_err;
   assign o_err_addr  = r_err_addr;
   assign o_psel      = r_psel;
   assign o_penable   = r_penable;
   assign o_pwrite    = r_pwrite;
   assign o_paddr     = r_paddr;
   assign o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_priority_sequencer.sv
module tb_apb_priority_sequencer;
  localparam int N  = 16;
  localparam int W  = 4;
  localparam int TO = 16;

  logic           pclk = 1'b0, presetn = 1'b0, start = 1'b0, pready = 1'b0;
  logic [N*W-1:0] prio_table = '0;
  logic           busy, cfg_valid, err, psel, penable, pwrite;
  logic [W-1:0]   err_addr, paddr, pwdata;

  apb_priority_sequencer #(.NO_OF_PERIPHERALS(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_pclk(pclk), .i_presetn(presetn), .i_start(start), .i_prio_table(prio_table),
    .o_busy(busy), .o_cfg_valid(cfg_valid), .o_err(err), .o_err_addr(err_addr),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
    .o_pwdata(pwdata), .i_pready(pready));

  always #5 pclk = ~pclk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected APB writes, pushed when a run is started.
  typedef struct { logic [W-1:0] a; logic [W-1:0] d; } wr_t;
  wr_t q[$];

  // Slave model: inserts wc wait cycles on address wa; monitor pops writes.
  int wa = 99, wc = 0, wcnt = 0;
  logic prev_psel = 0;
  logic [W-1:0] prev_addr = '0, prev_data = '0;

  always @(negedge pclk) begin
    if (psel && penable) begin
      if (int'(paddr) == wa) begin
        pready = (wcnt >= wc);
        wcnt++;
      end else pready = 1'b1;
    end else begin
      pready = 1'b0;
      wcnt = 0;
    end
    if (presetn) begin
      chk("pwrite_eq_psel", pwrite, psel);
      if (!psel) chk("bus_zero_idle", {paddr, pwdata}, '0);
      if (penable) begin
        chk("access_after_setup", {prev_psel, prev_addr, prev_data}, {1'b1, paddr, pwdata});
        if (pready) begin
          if (q.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", paddr, e.a);
            chk("wr_data", pwdata, e.d);
          end
        end
      end
    end
    prev_psel = psel; prev_addr = paddr; prev_data = pwdata;
  end

  task automatic do_start(input logic [N*W-1:0] tbl);
    @(negedge pclk);
    prio_table = tbl;
    start = 1'b1;
    q.delete();
    for (int k = 0; k < N; k++) q.push_back('{a: W'(k), d: tbl[k*W +: W]});
    @(negedge pclk);
    start = 1'b0;
    chk("first_setup", {busy, psel, penable, pwrite, paddr, pwdata, cfg_valid, err},
        {1'b1, 1'b1, 1'b0, 1'b1, 4'd0, tbl[W-1:0], 1'b0, 1'b0});
  endtask

  task automatic wait_idle(output int n);
    int bad;
    n = 1; bad = 0;
    while (busy && n < 2000) begin
      if (cfg_valid) bad++;
      @(negedge pclk);
      if (busy) n++;
    end
    chk("busy_bound", busy, 0);
    chk("cfgv_while_busy", bad, 0);
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(psel && int'(paddr) == a) && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("reach_addr", n < 200, 1);
  endtask

  typedef struct {
    int wa; int wc; int cyc; bit e; int ea; bit cv; int left;
  } vec_t;

  initial begin
    vec_t v[6];
    logic [N*W-1:0] tbl, ident;
    int n;

    v[0] = '{wa: 99, wc: 0,    cyc: 32, e: 0, ea: 0, cv: 1, left: 0};  // zero-wait
    v[1] = '{wa: 5,  wc: 3,    cyc: 35, e: 0, ea: 0, cv: 1, left: 0};  // 3 waits at 5
    v[2] = '{wa: 7,  wc: 1000, cyc: 31, e: 1, ea: 7, cv: 0, left: 9};  // stuck at 7
    v[3] = '{wa: 7,  wc: 15,   cyc: 47, e: 0, ea: 0, cv: 1, left: 0};  // ready on 16th
    v[4] = '{wa: 0,  wc: 1,    cyc: 33, e: 0, ea: 0, cv: 1, left: 0};  // wait on first
    v[5] = '{wa: 15, wc: 2,    cyc: 34, e: 0, ea: 0, cv: 1, left: 0};  // wait on last

    for (int k = 0; k < N; k++) ident[k*W +: W] = W'(k);

    repeat (3) @(negedge pclk);
    chk("reset_state", {busy, cfg_valid, err, err_addr, psel, penable, pwrite, paddr, pwdata}, '0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("idle_no_start", {busy, psel}, '0);

    for (int i = 0; i < 6; i++) begin
      wa = v[i].wa; wc = v[i].wc;
      tbl = (i == 0) ? ident : {$urandom, $urandom};
      do_start(tbl);
      wait_idle(n);
      chk($sformatf("run%0d_cycles", i), n, v[i].cyc);
      chk($sformatf("run%0d_err", i), err, v[i].e);
      if (v[i].e) chk($sformatf("run%0d_err_addr", i), err_addr, v[i].ea);
      chk($sformatf("run%0d_cfg_valid", i), cfg_valid, v[i].cv);
      chk($sformatf("run%0d_left", i), q.size(), v[i].left);
      if (v[i].e) begin
        repeat (3) @(negedge pclk);
        chk("err_sticky", {err, busy, psel, cfg_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
      end
      q.delete();
    end

    // start and table change while busy: ignored, snapshot is written
    wa = 99; wc = 0;
    tbl = {$urandom, $urandom};
    do_start(tbl);
    wait_addr(3);
    start = 1'b1;
    prio_table = ~tbl;
    @(negedge pclk);
    start = 1'b0;
    chk("busy_after_restart", {busy, psel}, 2'b11);
    wait_idle(n);
    chk("restart_ignored_done", {cfg_valid, err}, 2'b10);
    chk("restart_ignored_left", q.size(), 0);

    // reset mid-run at address 10, then a fresh run from address 0
    do_start(ident);
    wait_addr(10);
    presetn = 1'b0;
    @(negedge pclk);
    chk("midrun_reset", {busy, cfg_valid, err, err_addr, psel, penable, pwrite, paddr, pwdata}, '0);
    presetn = 1'b1;
    q.delete();
    @(negedge pclk);
    chk("no_resume", {busy, psel}, '0);
    tbl = {$urandom, $urandom};
    do_start(tbl);
    wait_idle(n);
    chk("post_reset_cycles", n, 32);
    chk("post_reset_done", {cfg_valid, err}, 2'b10);
    chk("post_reset_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_priority_sequencer.md
Name: apb_priority_sequencer

Overview:
- Boot-time and run-time configuration master for the interrupt controller's per-peripheral priority registers.
- Takes a flat priority table from a system input and issues one APB write per peripheral, addresses 0..NO_OF_PERIPHERALS-1, on the controller's slave port.
- Sits between the system/boot logic and the interrupt controller. `cfg_valid` tells downstream logic when the priority table is fully programmed, so it can gate `interrupt_active`.
- Detects a stalled slave with a `pready` timeout and reports the failing address.

Parameters:
- NO_OF_PERIPHERALS, 16, number of priority registers to program.
- WIDTH, $clog2(NO_OF_PERIPHERALS), address and priority width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles to wait for `pready`; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  reset, synchronous, active-low.
- start  in  1  request to program the table; sampled only in IDLE.
- prio_table  in  NO_OF_PERIPHERALS*WIDTH  priority of peripheral i at bits [i*WIDTH +: WIDTH].
- busy  out  1  high from SETUP of the first write until return to IDLE.
- cfg_valid  out  1  table fully programmed; level signal.
- err  out  1  last run aborted on timeout; sticky.
- err_addr  out  WIDTH  address whose write timed out.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write; 1 whenever psel=1.
- paddr  out  WIDTH  APB address.
- pwdata  out  WIDTH  APB write data.
- pready  in  1  APB slave ready.

Behaviour:
- Reset (presetn=0 at an edge): state=IDLE; busy, cfg_valid, err, psel, penable and pwrite = 0; paddr, pwdata and err_addr = 0; index and timeout counter = 0.
- Reset asserted mid-transfer: all outputs are driven to their reset values on that edge. The transfer is dropped and is not resumed.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE to SETUP: on an edge with start=1.
  - prio_table is snapshot into an internal table; later changes to the input do not affect the run.
  - index=0.
  - cfg_valid and err are cleared.
  - The cycle after this edge shows psel=1, penable=0, pwrite=1, paddr=0, pwdata=table[0].
- SETUP to ACCESS: unconditional after 1 cycle. penable=1; paddr and pwdata are held.
- ACCESS, pready=1 at an edge:
  - If index=N-1: go to IDLE; psel, penable and pwrite go to 0; busy goes to 0; cfg_valid goes to 1.
  - Otherwise: index+1, go to SETUP with the new paddr/pwdata. psel stays 1 and penable drops to 0.
- ACCESS, pready=0 at an edge: the timeout counter increments.
- Timeout (TIMEOUT_CYCLES>0): if the counter reaches TIMEOUT_CYCLES with no pready, that edge goes to IDLE.
  - err=1, err_addr=index.
  - psel, penable, pwrite and busy go to 0; cfg_valid stays 0.
- The timeout counter is cleared on every entry to SETUP.
- pready=1 on the final timeout cycle counts as success; pready has priority over the timeout.
- Zero-wait slave: 2 cycles per register. A 16-entry table completes with cfg_valid high 32 cycles after the start edge.
- start while busy: ignored. No restart, no queuing.
- start while cfg_valid=1: reprograms the table; cfg_valid falls on the start edge.
- paddr and pwdata are 0 whenever psel=0.

Test Plan:
- Zero-wait slave (pready tied 1), prio_table[i]=i, pulse start -> 16 writes observed, addr i / data i, each as SETUP then ACCESS; busy high 32 cycles; cfg_valid=1 on edge 32; err=0.
- Slave inserting 3 wait cycles on address 5 -> ACCESS for addr 5 lasts 4 cycles with paddr and pwdata stable; total run 35 cycles; no err.
- pready stuck 0 from address 7, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles: err=1, err_addr=7, psel=0, busy=0, cfg_valid=0.
- pready rises on exactly the 16th ACCESS cycle -> treated as success; sequence continues to address 8; err stays 0.
- start pulsed again at address 3 mid-run, and prio_table changed mid-run -> no restart; written data equals the table snapshot taken at the first start.
- presetn=0 at address 10, released, then start -> all outputs reset on that edge; the new run begins at address 0; err=0 and cfg_valid=0 until completion.
